// File: rtl/asrv32_memoryaccess.sv
// Load/store unit: runs one Wishbone-classic data transaction per memory instruction and
// stalls the core FSM until it completes. Misaligned accesses are flagged, never issued.
module asrv32_memoryaccess (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_opcode_load,
  input  logic        i_opcode_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2_data,
  output logic        o_stall,
  output logic [31:0] o_data_load,
  output logic        o_addr_misaligned_load,
  output logic        o_addr_misaligned_store,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t      state;
  logic        done_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        start;
  logic [3:0]  sel_next;
  logic [31:0] data_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign mem_op  = i_opcode_load | i_opcode_store;
  assign is_byte = (i_funct3[1:0] == 2'b00);
  assign is_half = (i_funct3[1:0] == 2'b01);
  assign is_word = ~(is_byte | is_half);

  assign misaligned = (is_half & i_addr[0]) | (is_word & (|i_addr[1:0]));

  // Combinational outputs are also gated by reset so every output reads 0 while it is held.
  assign o_addr_misaligned_load  = i_rst_n & i_ce & i_opcode_load  & misaligned;
  assign o_addr_misaligned_store = i_rst_n & i_ce & i_opcode_store & misaligned;
  assign o_stall = i_rst_n & i_ce & mem_op & ~misaligned & ~done_q;
  assign start   = i_ce & mem_op & ~misaligned & ~done_q & (state == S_IDLE);

  always_comb begin
    sel_next  = 4'b1111;
    data_next = i_rs2_data;
    if (is_byte) begin
      sel_next  = 4'b0001 << i_addr[1:0];
      data_next = {4{i_rs2_data[7:0]}};
    end else if (is_half) begin
      sel_next  = i_addr[1] ? 4'b1100 : 4'b0011;
      data_next = {2{i_rs2_data[15:0]}};
    end
  end

  always_comb begin
    byte_lane = i_wb_data[7:0];
    case (addr_lo_q)
      2'd1:    byte_lane = i_wb_data[15:8];
      2'd2:    byte_lane = i_wb_data[23:16];
      2'd3:    byte_lane = i_wb_data[31:24];
      default: byte_lane = i_wb_data[7:0];
    endcase
    half_lane = addr_lo_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{~funct3_q[2] & half_lane[15]}}, half_lane};
      default: load_ext = i_wb_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      done_q      <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= 32'h0;
      o_wb_data   <= 32'h0;
      o_wb_sel    <= 4'h0;
      o_data_load <= 32'h0;
    end else begin
      // done_q blocks a repeat access while the FSM lingers in MEMORYACCESS after completion.
      if (!i_ce) done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_BUS;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= i_opcode_store;
            o_wb_addr <= {i_addr[31:2], 2'b00};
            o_wb_sel  <= sel_next;
            o_wb_data <= i_opcode_store ? data_next : 32'h0;
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr[1:0];
          end
        end
        S_BUS: begin
          if (i_wb_ack) begin
            state    <= S_IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            done_q   <= 1'b1;
            if (!o_wb_we) o_data_load <= load_ext;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// Bench for asrv32_memoryaccess: directed cases plus randomized accesses checked against
// a byte-arithmetic reference model of size, lane, extension and alignment rules.
module tb_asrv32_memoryaccess;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ce;
  logic        i_opcode_load;
  logic        i_opcode_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_rs2_data;
  logic        o_stall;
  logic [31:0] o_data_load;
  logic        o_addr_misaligned_load;
  logic        o_addr_misaligned_store;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;

  int          n_checks;
  int          n_errors;
  int          n_txn;
  logic        cyc_prev;
  logic [31:0] ref_load;

  asrv32_memoryaccess dut (
    .i_clk                   (i_clk),
    .i_rst_n                 (i_rst_n),
    .i_ce                    (i_ce),
    .i_opcode_load           (i_opcode_load),
    .i_opcode_store          (i_opcode_store),
    .i_funct3                (i_funct3),
    .i_addr                  (i_addr),
    .i_rs2_data              (i_rs2_data),
    .o_stall                 (o_stall),
    .o_data_load             (o_data_load),
    .o_addr_misaligned_load  (o_addr_misaligned_load),
    .o_addr_misaligned_store (o_addr_misaligned_store),
    .o_wb_cyc                (o_wb_cyc),
    .o_wb_stb                (o_wb_stb),
    .o_wb_we                 (o_wb_we),
    .o_wb_addr               (o_wb_addr),
    .o_wb_data               (o_wb_data),
    .o_wb_sel                (o_wb_sel),
    .i_wb_ack                (i_wb_ack),
    .i_wb_data               (i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Counts bus transactions as rising edges of cyc.
  initial begin
    n_txn    = 0;
    cyc_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_wb_cyc && !cyc_prev) n_txn++;
      cyc_prev = o_wb_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (nbytes(f3))
      1:       return (rs2 & 32'hFF) * 32'h0101_0101;
      2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] bus);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n    = nbytes(f3);
    v    = bus >> (8 * (addr % 4));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] bus, input int waits, input int hold);
    logic issue;
    int   t0;
    issue = (ld | st) && !is_misal(f3, addr);
    t0    = n_txn;
    @(posedge i_clk); #1;
    i_ce = 1'b1; i_opcode_load = ld; i_opcode_store = st;
    i_funct3 = f3; i_addr = addr; i_rs2_data = rs2; i_wb_ack = 1'b0;
    @(negedge i_clk);
    check("c0_stall", o_stall, issue);
    check("c0_mis_ld", o_addr_misaligned_load, ld && is_misal(f3, addr));
    check("c0_mis_st", o_addr_misaligned_store, st && is_misal(f3, addr));
    check("c0_cyc", o_wb_cyc, 1'b0);
    if (issue) begin
      for (int w = 0; w <= waits; w++) begin
        @(posedge i_clk); #1;
        i_wb_ack   = (w == waits);
        i_wb_data  = (w == waits) ? bus : $urandom;
        i_rs2_data = $urandom;
        i_addr     = {$urandom_range(0, 32'h3FFF_FFFF), addr[1:0]};
        @(negedge i_clk);
        check("bus_cyc", o_wb_cyc, 1'b1);
        check("bus_stb", o_wb_stb, 1'b1);
        check("bus_addr", o_wb_addr, addr & 32'hFFFF_FFFC);
        check("bus_sel", o_wb_sel, exp_sel(f3, addr));
        check("bus_we", o_wb_we, st);
        check("bus_data", o_wb_data, st ? exp_wdata(f3, rs2) : 32'h0);
        check("bus_stall", o_stall, 1'b1);
      end
      @(posedge i_clk); #1;
      i_wb_ack  = 1'b0;
      i_wb_data = $urandom;
      if (ld) ref_load = exp_load(f3, addr, bus);
      @(negedge i_clk);
      check("done_stall", o_stall, 1'b0);
      check("done_cyc", o_wb_cyc, 1'b0);
      check("done_load", o_data_load, ref_load);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      i_wb_ack  = 1'($urandom_range(0, 1));
      i_wb_data = $urandom;
      @(negedge i_clk);
      check("hold_cyc", o_wb_cyc, 1'b0);
      check("hold_stall", o_stall, 1'b0);
      check("hold_load", o_data_load, ref_load);
    end
    @(posedge i_clk); #1;
    i_ce = 1'b0; i_wb_ack = 1'b0; i_opcode_load = 1'b0; i_opcode_store = 1'b0;
    @(negedge i_clk);
    check("txn_count", n_txn - t0, issue ? 1 : 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ref_load = 32'h0;
    i_rst_n = 1'b0; i_ce = 1'b0; i_opcode_load = 1'b0; i_opcode_store = 1'b0;
    i_funct3 = 3'b000; i_addr = 32'h0; i_rs2_data = 32'h0; i_wb_ack = 1'b0; i_wb_data = 32'h0;
    #12;
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_stb", o_wb_stb, 1'b0);
    check("rst_we", o_wb_we, 1'b0);
    check("rst_addr", o_wb_addr, 32'h0);
    check("rst_sel", o_wb_sel, 4'h0);
    check("rst_wdata", o_wb_data, 32'h0);
    check("rst_load", o_data_load, 32'h0);
    check("rst_stall", o_stall, 1'b0);
    @(negedge i_clk); #1;
    i_rst_n = 1'b1;

    // LW zero-wait, held two extra cycles after ack, then re-raised after one low cycle
    do_access(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 2);
    do_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 0);
    do_access(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0);
    do_access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_AAAA, 3, 0);
    do_access(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 2);
    do_access(0, 1, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 0, 2);
    do_access(0, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0, 2);
    do_access(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h8765_4321, 0, 0);
    do_access(1, 0, 3'b111, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 2, 1);

    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      do_access(kind < 5, kind >= 5 && kind < 9, 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of a bus cycle, then a fresh transaction with i_ce still high
    @(posedge i_clk); #1;
    i_ce = 1'b1; i_opcode_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_3000;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("pre_rst_cyc", o_wb_cyc, 1'b1);
    #1 i_rst_n = 1'b0;
    #1;
    check("arst_cyc", o_wb_cyc, 1'b0);
    check("arst_stb", o_wb_stb, 1'b0);
    check("arst_stall", o_stall, 1'b0);
    check("arst_load", o_data_load, 32'h0);
    ref_load = 32'h0;
    @(negedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_stall", o_stall, 1'b1);
    @(posedge i_clk); #1;
    i_wb_ack = 1'b1; i_wb_data = 32'h0BAD_F00D;
    @(negedge i_clk);
    check("post_rst_cyc", o_wb_cyc, 1'b1);
    check("post_rst_addr", o_wb_addr, 32'h0000_3000);
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    check("post_rst_load", o_data_load, 32'h0BAD_F00D);
    check("post_rst_done", o_stall, 1'b0);
    @(posedge i_clk); #1;
    i_ce = 1'b0; i_opcode_load = 1'b0;
    repeat (2) @(posedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asrv32_memoryaccess.md
# asrv32_memoryaccess

Load/store unit for the ASRV32 unpipelined core, sitting directly downstream of the core FSM's EXECUTE stage. It consumes the ALU result and `rs2` value while the FSM is in MEMORYACCESS. It runs one Wishbone-classic data-bus transaction per load or store, and stalls the FSM until the transaction completes. It returns sign/zero-extended load data to the writeback stage and flags misaligned accesses instead of issuing them.

## Interface
Parameters: none.
- `i_clk`  in  1  core clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_ce`  in  1  memory-access stage enable (FSM `o_memoryaccess_stage_en`), held high while FSM stalls
- `i_opcode_load`  in  1  current instruction is LOAD
- `i_opcode_store`  in  1  current instruction is STORE
- `i_funct3`  in  3  access size/sign, from `inst_q[14:12]`
- `i_addr`  in  32  effective address (ALU result)
- `i_rs2_data`  in  32  store data
- `o_stall`  out  1  FSM must hold MEMORYACCESS stage
- `o_data_load`  out  32  extended load result for writeback
- `o_addr_misaligned_load`  out  1  misaligned load detected
- `o_addr_misaligned_store`  out  1  misaligned store detected
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  data-bus control
- `o_wb_addr`  out  32  word address, `{i_addr[31:2],2'b00}`
- `o_wb_data`  out  32  write data
- `o_wb_sel`  out  4  byte enables
- `i_wb_ack`  in  1  bus acknowledge
- `i_wb_data`  in  32  bus read data

## Operation
- `mem_op` = `i_opcode_load | i_opcode_store`.
- Size rules:
  - `i_funct3[1:0]`=00 byte, 01 half, 10 word.
  - Misaligned when half and `i_addr[0]`=1, or when word and `i_addr[1:0]`≠0.
  - Misaligned flags are combinational, gated by `i_ce` and the matching opcode.
  - A misaligned access never starts a bus cycle and never raises `o_stall`.
- `start` = `i_ce & mem_op & !misaligned & !done_q & state==IDLE`.
- States:
  - IDLE: on `start`, register addr/sel/we/data and go to BUS.
  - BUS: `cyc`=`stb`=1. On `i_wb_ack`, capture extended load data into `o_data_load`, set `done_q`, and go to IDLE. Otherwise stay in BUS.
- `done_q` clears when `i_ce`=0. This prevents a second transaction while the FSM still sits in MEMORYACCESS after completion.
- `o_stall` = `i_ce & mem_op & !misaligned & !done_q` (combinational).
- Byte enables: byte `4'b0001<<addr[1:0]`; half `addr[1]` ? `1100` : `0011`; word `1111`.
- Store data: byte `{4{rs2[7:0]}}`, half `{2{rs2[15:0]}}`, word `rs2`. Loads drive `o_wb_data`=0 and `o_wb_we`=0.
- Load extension: select byte/half lane by `addr[1:0]`. `funct3[2]`=0 sign-extends; 1 zero-extends. Word loads pass through.
- `o_data_load` holds its value until the next load completes. Stores do not modify it.
- `funct3` values 011, 110, 111 are treated as word size (illegal-instruction detection is elsewhere).

## Timing
- Reset values:
  - All outputs are 0, including `o_wb_*`, `o_data_load`, `o_stall`, and the flags.
  - state = IDLE, `done_q` = 0.
  - Reset asserted mid-transaction drops `cyc`/`stb` immediately (asynchronous).
- Cycle sequence for a normal access (cycle indices as used by the test plan):
  - Cycle 0: `i_ce` rises, `o_stall`=1.
  - Cycle 1: `cyc`/`stb`/`addr`/`sel` valid.
  - Cycle k≥1: ack seen.
  - Cycle k+1: `o_stall`=0, `o_data_load` valid, bus idle.
- Minimum latency with zero-wait-state ack in cycle 1 is 3 cycles of `i_ce`.
- Bus outputs stay stable while in BUS, regardless of input changes.
- `i_wb_ack` outside BUS is ignored.
- `i_ce` with non-memory opcode: no bus activity, `o_stall`=0.

## Test plan
- LW, addr `0x0000_1004`, ack in cycle 1 with `0xDEADBEEF`:
  - `o_wb_addr`=`0x1004`, `sel`=`1111`, `we`=0.
  - `o_data_load`=`0xDEADBEEF`.
  - Stall high for exactly cycles 0–1.
- LB and LBU at addr `0x1003`, bus data `0x80xx_xxxx`:
  - LB: `sel`=`1000`, `o_data_load`=`0xFFFF_FF80`.
  - LBU: `o_data_load`=`0x0000_0080`.
- SH at addr `0x2002`, `rs2`=`0x1234_ABCD`, ack after 3 wait cycles:
  - `sel`=`1100`, `o_wb_data`=`0xABCD_ABCD`, `we`=1.
  - `cyc`/`stb` held for 4 cycles.
  - `o_data_load` unchanged.
- LW at `0x1002` and SH at `0x2001`:
  - Matching misaligned flag is 1, `o_stall`=0.
  - `cyc` never asserted.
- `i_ce` held high 2 cycles after ack:
  - Exactly one bus transaction occurs.
  - Re-raising `i_ce` after one low cycle starts a new one.
- `i_rst_n` pulsed low while in BUS:
  - `cyc`/`stb`/`o_stall` drop asynchronously.
  - After release with `i_ce`=1, a fresh transaction starts.
